// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store initiator for the word-organised riscv_mem.
// One request at a time: sub-word loads are extended, sub-word stores go
// through read-modify-write, and every request ends with a one-cycle
// response pulse.
// Optional build macro RISCV_LSU_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses are rejected with rsp_err. When undefined, the offending
// low address bits are treated as zero.
module riscv_lsu #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  // Memory and response outputs are registered; their _d values are
  // computed one cycle ahead, while deciding the next state.
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept_s;

  // Request legality: bad funct3, sub-word unsigned store, range, alignment.
  function automatic logic req_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic bad_f3;
    logic bad_st;
    logic bad_rng;
    logic bad_mis;
    bad_f3  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    bad_st  = we && f3[2];
    bad_rng = (addr >= ADDR_LIMIT);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    bad_mis = ((f3[1:0] == 2'b01) && addr[0]) ||
              ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    bad_mis = 1'b0;
`endif
    return bad_f3 || bad_st || bad_rng || bad_mis;
  endfunction

  // Byte offset used for lane selection; with trapping disabled, misaligned
  // halves/words collapse onto their naturally aligned position.
  function automatic logic [1:0] eff_off(input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic [1:0] r;
    case (f3[1:0])
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      2'b01:   r = lo;
`else
      2'b01:   r = {lo[1], 1'b0};
`endif
      2'b10:   r = 2'b00;
      default: r = lo;
    endcase
    return r;
  endfunction

  // Select the addressed lane (little-endian) and sign/zero extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Merge store data into the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          2'd3:    r[31:24] = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      3'b001: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;

  // Next-state and next-output logic; pulse outputs default to zero.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          we_d     = req_we;
          wdata_d  = req_wdata;
          if (req_err(req_we, req_funct3, req_addr)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_we || (req_funct3 != 3'b010)) begin
            // Loads and sub-word stores both need the current word first.
            state_d    = S_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end else begin
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // mem_rdata is valid combinationally while mem_re is high; it is
        // captured here either as the merged store word or the load result.
        if (we_q) begin
          state_d     = S_WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_q[31:2], 2'b00};
          mem_wdata_d = merge_store(mem_rdata, wdata_q, funct3_q,
                                    eff_off(funct3_q, addr_q[1:0]));
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = extend_load(mem_rdata, funct3_q,
                                    eff_off(funct3_q, addr_q[1:0]));
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      funct3_q    <= 3'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
